// File: rtl/bcd_timer_core_pkg.sv
// Shared definitions for the BCD timer: state and mode encodings, digit width
// and the preset-digit clamp helper.
package bcd_timer_core_pkg;

   localparam int DIG_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      MD_UP_ZERO   = 2'b00,
      MD_UP_PRESET = 2'b01,
      MD_DN_NINE   = 2'b10,
      MD_DN_PRESET = 2'b11
   } mode_t;

   function automatic logic [DIG_W-1:0] clamp9(input logic [DIG_W-1:0] d);
      if (d > 4'd9) begin
         clamp9 = 4'd9;
      end else begin
         clamp9 = d;
      end
   endfunction

   function automatic logic is_up(input mode_t m);
      is_up = ~m[1];
   endfunction

endpackage

// File: rtl/bcd_timer_core_digit.sv
// One BCD digit: parallel load, and a single up/down step gated by the
// incoming carry/borrow; the carry/borrow out ripples to the next digit.
module bcd_digit
   import bcd_timer_core_pkg::*;
(
   input  logic             c_clk,
   input  logic             C_clr,
   input  logic             load,
   input  logic [DIG_W-1:0] load_val,
   input  logic             step,
   input  logic             up,
   input  logic             cin,
   output logic [DIG_W-1:0] q,
   output logic             cout
);

   logic at_bound_s;

   assign at_bound_s = up ? (q == 4'd9) : (q == 4'd0);
   assign cout       = cin & at_bound_s;

   // digit register: load wins over step; a digit at its bound wraps and passes carry on
   always_ff @(posedge c_clk or posedge C_clr) begin
      if (C_clr) begin
         q <= 4'd0;
      end else if (load) begin
         q <= load_val;
      end else if (step && cin) begin
         if (at_bound_s) begin
            q <= up ? 4'd0 : 4'd9;
         end else begin
            q <= up ? (q + 4'd1) : (q - 4'd1);
         end
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/bcd_timer_core.sv
// BCD up/down timer: IDLE/RUN/PAUSE/DONE controller, terminal detection and
// a ripple chain of bcd_digit instances.
module bcd_timer_core
   import bcd_timer_core_pkg::*;
#(
   parameter int NDIG   = 4,
   parameter int DP_POS = 2
) (
   input  logic                  c_clk,
   input  logic                  C_clr,
   input  logic                  tick,
   input  logic                  sp,
   input  logic                  clr,
   input  logic [1:0]            mode,
   input  logic [DIG_W*NDIG-1:0] preset,
   output logic [DIG_W*NDIG-1:0] count,
   output logic [1:0]            state,
   output logic                  running,
   output logic                  done,
   output logic [NDIG-1:0]       dp_sel
);

   localparam logic [DIG_W*NDIG-1:0] ALL9 = {NDIG{4'h9}};
   localparam logic [DIG_W*NDIG-1:0] ALL0 = {(DIG_W*NDIG){1'b0}};

   state_t                  state_r;
   state_t                  next_s;
   mode_t                   mode_r;
   logic                    running_r;
   logic                    done_r;
   logic [DIG_W*NDIG-1:0]   start_s;
   logic [DIG_W*NDIG-1:0]   term_val_s;
   logic [NDIG:0]           chain_s;
   logic                    up_s;
   logic                    load_s;
   logic                    step_s;
   logic                    terminal_s;
   logic                    wrap_s;

   // start value from the live mode/preset inputs; only used while loading
   always_comb begin
      start_s = ALL0;
      for (int i = 0; i < NDIG; i++) begin
         case (mode_t'(mode))
            MD_UP_ZERO: start_s[i*DIG_W +: DIG_W] = 4'd0;
            MD_DN_NINE: start_s[i*DIG_W +: DIG_W] = 4'd9;
            default:    start_s[i*DIG_W +: DIG_W] = clamp9(preset[i*DIG_W +: DIG_W]);
         endcase
      end
   end

   assign up_s       = is_up(mode_r);
   assign term_val_s = up_s ? ALL9 : ALL0;
   assign terminal_s = (count == term_val_s);
   // a carry out of the top digit means the step would wrap past terminal
   assign wrap_s     = chain_s[NDIG];
   assign load_s     = clr || (state_r == ST_IDLE);
   assign step_s     = (state_r == ST_RUN) && tick && !wrap_s;
   assign chain_s[0] = 1'b1;

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      bcd_digit u_digit (
         .c_clk    (c_clk),
         .C_clr    (C_clr),
         .load     (load_s),
         .load_val (start_s[i*DIG_W +: DIG_W]),
         .step     (step_s),
         .up       (up_s),
         .cin      (chain_s[i]),
         .q        (count[i*DIG_W +: DIG_W]),
         .cout     (chain_s[i+1])
      );
   end

   for (genvar i = 0; i < NDIG; i++) begin : g_dp
      assign dp_sel[i] = (i == DP_POS) ? 1'b1 : 1'b0;
   end

   // next-state logic, clr first, then sp, then terminal detection
   always_comb begin
      next_s = state_r;
      if (clr) begin
         next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:  next_s = sp ? ST_RUN : ST_IDLE;
            ST_RUN: begin
               if (sp) begin
                  next_s = ST_PAUSE;
               end else if (terminal_s) begin
                  next_s = ST_DONE;
               end else begin
                  next_s = ST_RUN;
               end
            end
            ST_PAUSE: next_s = sp ? ST_RUN : ST_PAUSE;
            ST_DONE:  next_s = ST_DONE;
            default:  next_s = ST_IDLE;
         endcase
      end
   end

   // state register with registered status flags
   always_ff @(posedge c_clk or posedge C_clr) begin
      if (C_clr) begin
         state_r   <= ST_IDLE;
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= next_s;
         running_r <= (next_s == ST_RUN);
         done_r    <= (next_s == ST_DONE);
      end
   end

   // mode is frozen outside IDLE so a mid-run change cannot flip direction
   always_ff @(posedge c_clk or posedge C_clr) begin
      if (C_clr) begin
         mode_r <= MD_UP_ZERO;
      end else if (state_r == ST_IDLE) begin
         mode_r <= mode_t'(mode);
      end else begin
         mode_r <= mode_r;
      end
   end

   assign state   = state_r;
   assign running = running_r;
   assign done    = done_r;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Directed bench for bcd_timer_core (NDIG=4, DP_POS=2).
module tb_bcd_timer_core;

   logic        c_clk = 1'b0;
   logic        C_clr;
   logic        tick;
   logic        sp;
   logic        clr;
   logic [1:0]  mode;
   logic [15:0] preset;
   logic [15:0] count;
   logic [1:0]  state;
   logic        running;
   logic        done;
   logic [3:0]  dp_sel;

   int n_cmp = 0;
   int n_err = 0;

   always #5 c_clk = ~c_clk;

   bcd_timer_core #(.NDIG(4), .DP_POS(2)) dut (
      .c_clk   (c_clk),
      .C_clr   (C_clr),
      .tick    (tick),
      .sp      (sp),
      .clr     (clr),
      .mode    (mode),
      .preset  (preset),
      .count   (count),
      .state   (state),
      .running (running),
      .done    (done),
      .dp_sel  (dp_sel)
   );

   function automatic logic [15:0] to_bcd(input int v);
      to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge c_clk);
      #1;
   endtask

   initial begin
      C_clr = 1'b0; tick = 1'b0; sp = 1'b0; clr = 1'b0;
      mode = 2'b01; preset = 16'h12F9;
      #1 C_clr = 1'b1;
      #1;
      check("rst_count",   32'(count),   32'h0000);
      check("rst_state",   32'(state),   32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_done",    32'(done),    32'h0);
      check("dp_sel",      32'(dp_sel),  32'h4);
      #1 C_clr = 1'b0;

      // preset with clamped digit, sp+tick together, PAUSE holds
      cyc();
      check("idle_clamp", 32'(count), 32'h1299);
      check("idle_state", 32'(state), 32'h0);
      sp = 1'b1;
      cyc();
      check("sp_to_run", 32'(state), 32'h1);
      check("run_flag",  32'(running), 32'h1);
      check("run_count", 32'(count), 32'h1299);
      tick = 1'b1;
      cyc();
      check("sp_tick_count", 32'(count), 32'h1300);
      check("sp_tick_state", 32'(state), 32'h2);
      check("pause_running", 32'(running), 32'h0);
      sp = 1'b0; preset = 16'h5555;
      cyc();
      check("pause_hold",  32'(count), 32'h1300);
      check("pause_state", 32'(state), 32'h2);
      tick = 1'b0; clr = 1'b1;
      cyc();
      check("clr_pause", 32'(state), 32'h0);
      clr = 1'b0;
      cyc();
      check("reload_preset", 32'(count), 32'h5555);

      // full up count with a mid-run mode change that must be ignored
      mode = 2'b00;
      cyc();
      check("up_zero_start", 32'(count), 32'h0000);
      sp = 1'b1;
      cyc();
      check("up_run", 32'(state), 32'h1);
      sp = 1'b0; tick = 1'b1;
      for (int k = 1; k <= 9999; k++) begin
         if (k == 5000) mode = 2'b11;
         cyc();
         check("up_seq", 32'(count), 32'(to_bcd(k)));
      end
      check("run_at_9999", 32'(state), 32'h1);
      cyc();
      check("done_state", 32'(state), 32'h3);
      check("done_flag",  32'(done),  32'h1);
      check("done_count", 32'(count), 32'h9999);
      cyc();
      check("no_overflow", 32'(count), 32'h9999);
      tick = 1'b0; sp = 1'b1;
      cyc();
      check("sp_in_done", 32'(state), 32'h3);
      sp = 1'b0; clr = 1'b1;
      cyc();
      check("clr_done", 32'(state), 32'h0);
      clr = 1'b0;
      cyc();
      check("reload_after_done", 32'(count), 32'h5555);
      check("done_cleared",      32'(done),  32'h0);

      // async clear mid-run
      mode = 2'b00;
      cyc();
      sp = 1'b1;
      cyc();
      sp = 1'b0; tick = 1'b1;
      repeat (457) cyc();
      tick = 1'b0;
      check("up_457", 32'(count), 32'h0457);
      #2 C_clr = 1'b1;
      #1;
      check("async_count",   32'(count),   32'h0000);
      check("async_state",   32'(state),   32'h0);
      check("async_running", 32'(running), 32'h0);
      C_clr = 1'b0;
      cyc();
      check("post_rst_idle", 32'(state), 32'h0);
      check("post_rst_load", 32'(count), 32'h0000);

      // down from preset 0100
      mode = 2'b11; preset = 16'h0100;
      cyc();
      check("dn_start", 32'(count), 32'h0100);
      sp = 1'b1;
      cyc();
      sp = 1'b0; tick = 1'b1;
      cyc();
      check("dn_first", 32'(count), 32'h0099);
      for (int k = 2; k <= 100; k++) begin
         cyc();
         check("dn_seq", 32'(count), 32'(to_bcd(100 - k)));
      end
      check("dn_run_at_0", 32'(state), 32'h1);
      cyc();
      check("dn_done",       32'(done),  32'h1);
      check("dn_done_count", 32'(count), 32'h0000);
      cyc();
      check("no_underflow", 32'(count), 32'h0000);
      tick = 1'b0; clr = 1'b1;
      cyc();
      clr = 1'b0;

      // start equal to terminal: one RUN cycle then DONE
      preset = 16'h0000;
      cyc();
      check("term_start", 32'(count), 32'h0000);
      sp = 1'b1;
      cyc();
      check("term_run", 32'(state), 32'h1);
      sp = 1'b0; tick = 1'b1;
      cyc();
      check("term_done",  32'(state), 32'h3);
      check("term_count", 32'(count), 32'h0000);
      tick = 1'b0; clr = 1'b1;
      cyc();
      clr = 1'b0; mode = 2'b10;
      cyc();
      check("all9_start", 32'(count), 32'h9999);
      mode = 2'b11; preset = 16'hFAFB;
      cyc();
      check("clamp_all", 32'(count), 32'h9999);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
